value_entry: RTL

VALUE_ENTRY -- requirements
Module: value_entry

---
 rtl/value_entry_pkg.sv | 14 +
 rtl/value_entry_button_conditioner.sv | 58 +++++
 rtl/value_entry.sv | 117 +++++++++++
 3 files changed

// File: rtl/value_entry_pkg.sv
// Shared definitions for the value_entry push-button value editor:
// FSM state encoding and default parameter values.
package value_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 5;
    localparam int DEFAULT_DB_COUNT = 250000;

endpackage

// File: rtl/value_entry_button_conditioner.sv
// Conditions one raw push-button: 2-flop synchronizer, debouncer and
// rising-edge detector.
// Ports: clk, reset (async, active high), btn_raw (raw input),
//        pulse (one-cycle high on each debounced 0->1 transition).
module button_conditioner
    import value_entry_pkg::*;
#(
    parameter int DB_COUNT = DEFAULT_DB_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = $clog2(DB_COUNT + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count runs only while the synchronized input disagrees with the
    // accepted level; any agreement (a bounce back) restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DB_COUNT - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = stable_q & ~prev_q;

endmodule

// File: rtl/value_entry.sv
// Push-button value editor: up/down edit a WIDTH-bit value, enter commits
// it (enable held high), clear returns to idle.
// Ports: clk, reset (async, active high), btn_up/btn_down/btn_enter/
//        btn_clear (raw buttons), Data (current value), enable (committed
//        value held), editing (in EDIT).
module value_entry
    import value_entry_pkg::*;
#(
    parameter int DB_COUNT = DEFAULT_DB_COUNT,
    parameter int WIDTH    = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] Data,
    output logic             enable,
    output logic             editing
);

    logic p_up;
    logic p_down;
    logic p_enter;
    logic p_clear;

    button_conditioner #(.DB_COUNT(DB_COUNT)) u_up (
        .clk(clk), .reset(reset), .btn_raw(btn_up), .pulse(p_up)
    );
    button_conditioner #(.DB_COUNT(DB_COUNT)) u_down (
        .clk(clk), .reset(reset), .btn_raw(btn_down), .pulse(p_down)
    );
    button_conditioner #(.DB_COUNT(DB_COUNT)) u_enter (
        .clk(clk), .reset(reset), .btn_raw(btn_enter), .pulse(p_enter)
    );
    button_conditioner #(.DB_COUNT(DB_COUNT)) u_clear (
        .clk(clk), .reset(reset), .btn_raw(btn_clear), .pulse(p_clear)
    );

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             enable_q;
    logic             enable_d;
    logic             editing_q;
    logic             editing_d;

    // Only the highest-priority pulse acts: clear > enter > up > down.
    logic act_enter;
    logic act_up;
    logic act_down;

    assign act_enter = p_enter & ~p_clear;
    assign act_up    = p_up & ~p_clear & ~p_enter;
    assign act_down  = p_down & ~p_clear & ~p_enter & ~p_up;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                value_d = '0;
                if (act_up) begin
                    state_d = ST_EDIT;
                    value_d = WIDTH'(1);
                end else if (act_down) begin
                    state_d = ST_EDIT;
                    value_d = '1;
                end
            end
            ST_EDIT, ST_HOLD: begin
                if (act_enter) begin
                    if (state_q == ST_EDIT) begin
                        state_d = ST_HOLD;
                    end
                end else if (act_up) begin
                    state_d = ST_EDIT;
                    value_d = value_q + WIDTH'(1);
                end else if (act_down) begin
                    state_d = ST_EDIT;
                    value_d = value_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                value_d = '0;
            end
        endcase
        if (p_clear) begin
            state_d = ST_IDLE;
            value_d = '0;
        end
        enable_d  = (state_d == ST_HOLD);
        editing_d = (state_d == ST_EDIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            enable_q  <= 1'b0;
            editing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            enable_q  <= enable_d;
            editing_q <= editing_d;
        end
    end

    assign Data    = value_q;
    assign enable  = enable_q;
    assign editing = editing_q;

endmodule
